// File: rtl/csa_stream_accumulator_pkg.sv
// Shared constants and FSM encoding for the carry-save stream accumulator.
package csa_stream_accumulator_pkg;

  localparam int DEF_W_IN  = 4;
  localparam int DEF_W_ACC = 12;
  localparam int DEF_W_CNT = 8;

  // 2'd3 is unused; the FSM treats it as illegal and falls back to ACCUM.
  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

endpackage

// File: rtl/csa_stream_accumulator_csa_row.sv
// One 3:2 compression row: bitwise full adders, carry vector left unshifted
// so the caller decides what to do with the top carry bit.
module csa_row #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cy
);

  for (genvar i = 0; i < W; i++) begin : g_fa
    fulladder u_fa (
      .s    (s[i]),
      .cout (cy[i]),
      .a    (a[i]),
      .b    (b[i]),
      .c    (c[i])
    );
  end

endmodule

// File: rtl/fulladder.sv
// Single-bit full-adder cell shared by the carry-save row and the final CPA.
module fulladder (
  output logic s,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic c
);

  // Sum is odd parity, carry is the majority of the three inputs.
  always_comb begin
    s    = a ^ b ^ c;
    cout = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/csa_stream_accumulator.sv
// Multi-operand stream adder: carry-save accumulation per beat, one ripple
// carry-propagate add on the cycle after the last beat of a group.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. Producers hold valid and payload until the transfer; ready may
// change freely. in_ready is high only in ACCUM; out_valid stays high with a
// stable payload until out_ready is seen high.
module csa_stream_accumulator
  import csa_stream_accumulator_pkg::*;
#(
  parameter int W_IN  = DEF_W_IN,
  parameter int W_ACC = DEF_W_ACC,
  parameter int W_CNT = DEF_W_CNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_ACC-1:0] out_sum,
  output logic [W_CNT-1:0] out_count,
  output logic             out_ovf
);

  state_t             state_q, state_d;
  logic [W_ACC-1:0]   ps_q, ps_d;
  logic [W_ACC-1:0]   pc_q, pc_d;
  logic [W_CNT-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [W_ACC-1:0]   out_sum_q, out_sum_d;
  logic [W_CNT-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic [W_ACC-1:0]   x;
  logic [W_ACC-1:0]   row_s;
  logic [W_ACC-1:0]   row_c;
  logic [W_ACC-1:0]   res_s;
  logic [W_ACC:0]     res_c;

  assign x = {{(W_ACC - W_IN){1'b0}}, in_data};

  csa_row #(.W(W_ACC)) u_row (
    .a  (ps_q),
    .b  (pc_q),
    .c  (x),
    .s  (row_s),
    .cy (row_c)
  );

  // Ripple carry-propagate adder that resolves the redundant pair.
  assign res_c[0] = 1'b0;
  for (genvar i = 0; i < W_ACC; i++) begin : g_cpa
    fulladder u_fa (
      .s    (res_s[i]),
      .cout (res_c[i+1]),
      .a    (ps_q[i]),
      .b    (pc_q[i]),
      .c    (res_c[i])
    );
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // Next-state and datapath update for the three-state group FSM.
  always_comb begin
    state_d     = state_q;
    ps_d        = ps_q;
    pc_d        = pc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          ps_d = row_s;
          // The carry leaving the top bit has weight 2^W_ACC: fold it into
          // the sticky overflow instead of losing it in the shift.
          pc_d  = {row_c[W_ACC-2:0], 1'b0};
          ovf_d = ovf_q | row_c[W_ACC-1];
          if (count_q != {W_CNT{1'b1}}) begin
            count_d = count_q + W_CNT'(1);
          end
          if (in_last) begin
            state_d = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        out_sum_d   = res_s;
        out_ovf_d   = ovf_q | res_c[W_ACC];
        out_count_d = count_q;
        out_valid_d = 1'b1;
        ps_d        = '0;
        pc_d        = '0;
        count_d     = '0;
        ovf_d       = 1'b0;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: begin
        ps_d        = '0;
        pc_d        = '0;
        count_d     = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b0;
        state_d     = ACCUM;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      ps_q        <= '0;
      pc_q        <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ps_q        <= ps_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed and randomized-gap bench for csa_stream_accumulator.
module tb_csa_stream_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  int n_cmp;
  int n_err;

  csa_stream_accumulator #(.W_IN(4), .W_ACC(12), .W_CNT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // protocol monitor: payload stable while stalled, never both ready and valid
  logic        mon_en;
  logic        p_valid, p_ready, p_rst, p_ovf;
  logic [11:0] p_sum;
  logic [7:0]  p_count;
  initial begin
    mon_en  = 1'b0;
    p_valid = 1'b0;
    p_ready = 1'b0;
    p_rst   = 1'b1;
    p_sum   = '0;
    p_count = '0;
    p_ovf   = 1'b0;
  end
  always @(negedge clk) begin
    if (mon_en) begin
      if (p_valid && !p_ready && !p_rst) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== p_sum || out_count !== p_count || out_ovf !== p_ovf) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0b sum=%0d cnt=%0d ovf=%0b, want v=1 sum=%0d cnt=%0d ovf=%0b",
                   out_valid, out_sum, out_count, out_ovf, p_sum, p_count, p_ovf);
        end
      end
      if (in_ready && out_valid) begin
        n_cmp++;
        n_err++;
        $display("FAIL ready_valid_overlap: got in_ready=1 out_valid=1, want not both");
      end
    end
    p_valid = out_valid;
    p_ready = out_ready;
    p_rst   = rst;
    p_sum   = out_sum;
    p_count = out_count;
    p_ovf   = out_ovf;
  end

  // driver: present one beat and hold it until accepted
  task automatic send_beat(input logic [3:0] d, input logic l);
    int n;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 after %0d cycles, want 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // driver: wait for a result, stall `hold` cycles, then accept it
  task automatic get_result(input int hold, output logic [11:0] s, output logic [7:0] c,
                            output logic o);
    int n;
    out_ready = 1'b0;
    n = 0;
    s = 'x;
    c = 'x;
    o = 1'bx;
    while (!out_valid && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL result_timeout: got out_valid=0 after %0d cycles, want 1", n);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
      end
      s = out_sum;
      c = out_count;
      o = out_ovf;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 12'd0 || out_count !== 8'd0 || out_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%0b v=%0b sum=%0d cnt=%0d ovf=%0b, want 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    end
  endtask

  task automatic test_three_fifteens();
    logic [11:0] s;
    logic [7:0]  c;
    logic        o;
    send_beat(4'd15, 1'b0);
    send_beat(4'd15, 1'b0);
    send_beat(4'd15, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: got out_valid=%0b right after last beat, want 0", out_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL latency_one: got out_valid=%0b one cycle after last, want 1", out_valid);
    end
    get_result(0, s, c, o);
    n_cmp++;
    if (s !== 12'd45 || c !== 8'd3 || o !== 1'b0) begin
      n_err++;
      $display("FAIL three_15: got sum=%0d cnt=%0d ovf=%0b, want 45 3 0", s, c, o);
    end
  endtask

  task automatic test_single_beat();
    logic [11:0] s;
    logic [7:0]  c;
    logic        o;
    send_beat(4'd9, 1'b1);
    get_result(0, s, c, o);
    n_cmp++;
    if (s !== 12'd9 || c !== 8'd1 || o !== 1'b0) begin
      n_err++;
      $display("FAIL single_beat: got sum=%0d cnt=%0d ovf=%0b, want 9 1 0", s, c, o);
    end
  endtask

  task automatic test_saturation();
    logic [11:0] s;
    logic [7:0]  c;
    logic        o;
    for (int i = 0; i < 274; i++) begin
      send_beat(4'd15, (i == 273));
    end
    get_result(0, s, c, o);
    n_cmp++;
    if (s !== 12'd14 || c !== 8'd255 || o !== 1'b1) begin
      n_err++;
      $display("FAIL saturate_274: got sum=%0d cnt=%0d ovf=%0b, want 14 255 1", s, c, o);
    end
  endtask

  task automatic test_stall();
    logic [11:0] s;
    logic [7:0]  c;
    logic        o;
    int          n;
    send_beat(4'd3, 1'b0);
    send_beat(4'd4, 1'b1);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    in_data  = 4'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_sum !== 12'd7 || out_count !== 8'd2 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_%0d: got v=%0b sum=%0d cnt=%0d rdy=%0b, want 1 7 2 0",
                 i, out_valid, out_sum, out_count, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    get_result(0, s, c, o);
    n_cmp++;
    if (s !== 12'd7 || c !== 8'd2 || o !== 1'b0) begin
      n_err++;
      $display("FAIL stall_result: got sum=%0d cnt=%0d ovf=%0b, want 7 2 0", s, c, o);
    end
    send_beat(4'd1, 1'b0);
    send_beat(4'd1, 1'b1);
    get_result(0, s, c, o);
    n_cmp++;
    if (s !== 12'd2 || c !== 8'd2 || o !== 1'b0) begin
      n_err++;
      $display("FAIL after_stall: got sum=%0d cnt=%0d ovf=%0b, want 2 2 0", s, c, o);
    end
  endtask

  task automatic test_reset_midgroup();
    logic [11:0] s;
    logic [7:0]  c;
    logic        o;
    send_beat(4'd5, 1'b0);
    send_beat(4'd6, 1'b0);
    do_reset();
    send_beat(4'd2, 1'b1);
    get_result(0, s, c, o);
    n_cmp++;
    if (s !== 12'd2 || c !== 8'd1 || o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midgroup: got sum=%0d cnt=%0d ovf=%0b, want 2 1 0", s, c, o);
    end
    send_beat(4'd8, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_output_reset: got out_valid=%0b, want 1", out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 12'd0) begin
      n_err++;
      $display("FAIL reset_output: got v=%0b rdy=%0b sum=%0d, want 0 1 0", out_valid, in_ready, out_sum);
    end
  endtask

  task automatic test_random();
    logic [11:0] s;
    logic [7:0]  c;
    logic        o;
    int          nb;
    int          total;
    int          gap;
    logic [3:0]  d;
    for (int g = 0; g < 1000; g++) begin
      nb    = (g % 50 == 49) ? $urandom_range(260, 300) : $urandom_range(1, 8);
      total = 0;
      for (int b = 0; b < nb; b++) begin
        gap = $urandom_range(0, 2);
        for (int k = 0; k < gap; k++) begin
          @(posedge clk); #1;
        end
        d = 4'($urandom_range(0, 15));
        total += int'(d);
        send_beat(d, (b == nb - 1));
      end
      get_result($urandom_range(0, 3), s, c, o);
      n_cmp++;
      if (s !== 12'(total % 4096)) begin
        n_err++;
        $display("FAIL rand_sum g=%0d: got %0d, want %0d", g, s, total % 4096);
      end
      n_cmp++;
      if (o !== (total >= 4096)) begin
        n_err++;
        $display("FAIL rand_ovf g=%0d: got %0b, want %0b", g, o, (total >= 4096));
      end
      n_cmp++;
      if (c !== 8'((nb > 255) ? 255 : nb)) begin
        n_err++;
        $display("FAIL rand_count g=%0d: got %0d, want %0d", g, c, (nb > 255) ? 255 : nb);
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_three_fifteens();
    test_single_beat();
    test_saturation();
    test_stall();
    test_reset_midgroup();
    test_random();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Sequential multi-operand adder. Accepts a stream of W_IN-bit unsigned operands and keeps the running total in redundant carry-save form, one 3:2 compression per accepted beat.
- On the beat marked last, it resolves the sum/carry pair with one carry-propagate add and presents the total.
- It sits upstream of the final ripple/CPA stage and reuses the same full-adder cell.

Parameters:
- W_IN, 4, operand width in bits.
- W_ACC, 12, accumulator and result width in bits (W_ACC > W_IN).
- W_CNT, 8, beat-counter width; the counter saturates at 2^W_CNT-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  W_IN  unsigned operand, zero-extended to W_ACC.
- in_last  input  1  marks the final operand of a group; qualified by the handshake.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  W_ACC  resolved total, modulo 2^W_ACC.
- out_count  output  W_CNT  number of operands in the group, saturating.
- out_ovf  output  1  true total is >= 2^W_ACC.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=ACCUM; ps, pc, count and ovf all 0.
  - in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - Reset overrides any in-flight group or pending result; there is no partial output.
- Input handshake: a beat transfers when in_valid && in_ready on a clk edge. in_ready=1 only in ACCUM.
- State ACCUM, per accepted beat:
  - x = zext(in_data).
  - ps <= ps ^ pc ^ x.
  - pc <= (maj(ps,pc,x) << 1) truncated to W_ACC.
  - The majority bit shifted out at position W_ACC-1 ORs into the sticky ovf.
  - count <= count+1, saturating at all-ones.
  - If in_last, go to RESOLVE.
- State RESOLVE, one cycle:
  - {c, r} = ps + pc, a W_ACC-bit carry-propagate add.
  - out_sum <= r; out_ovf <= ovf | c; out_count <= count.
  - out_valid <= 1; go to OUTPUT.
  - Clear ps, pc, count and ovf.
- State OUTPUT:
  - Hold out_sum, out_count and out_ovf stable while out_valid=1 && out_ready=0.
  - On out_ready=1: out_valid <= 0, go to ACCUM. Outputs keep their last values, but they are don't-care while out_valid=0.
- Latency: last beat accepted at edge t, RESOLVE executes at edge t+1, out_valid is high after edge t+1. The earliest next input acceptance is the edge after out_ready is sampled high. No overlap between groups.
- Group size: a group always holds at least 1 operand; there is no empty-group mechanism. A single-beat group (in_last on the first beat) is legal.
- in_last while not in ACCUM has no effect, because no transfer occurs.
- Invariants:
  - ps + pc + ovf·2^W_ACC equals the true partial total (mod 2^(W_ACC+1) is sufficient).
  - ovf is exact: 1 iff the true total >= 2^W_ACC.
- Counter saturation does not affect out_sum or out_ovf.
- in_data and in_last are sampled only on the handshake edge.

Decomposition:
- Shared header/package:
  - State encoding: ACCUM=2'd0, RESOLVE=2'd1, OUTPUT=2'd2; 2'd3 is illegal and recovers to ACCUM.
  - Default width constants W_IN, W_ACC, W_CNT.
- Sub-module csa_row: W_ACC-wide generate loop of the existing fulladder cell (s, cout, a, b, c) that produces the sum vector and the unshifted carry vector.
- The RESOLVE adder is a second generate loop of fulladder cells inside the top module.

Test Plan:
- Beats 15, 15, 15 (last on 3rd), out_ready=1 → out_sum=45, out_count=3, out_ovf=0, out_valid exactly 1 cycle after the last handshake.
- Single beat 9 with last → out_sum=9, out_count=1, out_ovf=0.
- 274 beats of 15 → out_sum=14 (4110-4096), out_ovf=1, out_count=255 (saturated).
- Group 3, 4 (last) with out_ready held 0 for 5 cycles → out_valid, out_sum=7 and out_count=2 stable throughout; in_ready=0 and offered beats are not consumed. Next group 1, 1 (last) → out_sum=2, so no state leaks from the previous group.
- rst asserted after 2 beats (5, 6) of a group → next group 2 (last) yields out_sum=2, out_count=1. Also, rst during OUTPUT → out_valid=0 on the next cycle.
- Random valid gaps and random out_ready over 1000 groups → out_sum and out_ovf match a reference model sum (mod 4096, overflow flag); handshake protocol assertions hold.
